// File: rtl/pll_lock_supervisor.sv
// PLL bring-up/recovery sequencer on the 10 MHz reference clock: waits for stable lock,
// pulses the sticky-lock clear, holds system reset, then tracks lock loss and timeouts.
module pll_lock_supervisor #(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             clk_10m,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             pll_locked_stdy,
  output logic             stdy_rst,
  output logic             sys_rst_req,
  output logic             sys_ready,
  output logic             lock_timeout,
  output logic [CNT_W-1:0] unlock_count
);

  localparam int unsigned STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    CLEAR_STDY = 3'd2,
    HOLD       = 3'd3,
    RUN        = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               lock_s1_q, lock_s2_q, stdy_s1_q, stdy_s2_q;
  logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               clr_cnt_q, clr_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   unlock_q, unlock_d;
  logic               stdy_rst_q, sys_rst_req_q, sys_ready_q;

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    hold_cnt_d = hold_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
    unlock_d   = unlock_q;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s2_q) begin
          state_d    = STABLE;
          stab_cnt_d = '0;
        end
      end
      STABLE: begin
        if (!lock_s2_q) begin
          state_d = WAIT_LOCK;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d   = CLEAR_STDY;
          clr_cnt_d = 1'b0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      // Two-cycle sticky clear pulse; lock is deliberately not watched here.
      CLEAR_STDY: begin
        if (clr_cnt_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s2_q) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          if (stdy_s2_q) state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s2_q || !stdy_s2_q) begin
          state_d = WAIT_LOCK;
          if (unlock_q != '1) unlock_d = unlock_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Timeout accumulates across lock flapping; only entering RUN clears it.
    if (state_q != RUN) begin
      if (state_d == RUN) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q != TMO_LAST) begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_cnt_d == TMO_LAST) timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_10m) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      lock_s1_q     <= 1'b0;
      lock_s2_q     <= 1'b0;
      stdy_s1_q     <= 1'b0;
      stdy_s2_q     <= 1'b0;
      stab_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      clr_cnt_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      timeout_q     <= 1'b0;
      unlock_q      <= '0;
      stdy_rst_q    <= 1'b0;
      sys_rst_req_q <= 1'b1;
      sys_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_s1_q     <= pll_locked;
      lock_s2_q     <= lock_s1_q;
      stdy_s1_q     <= pll_locked_stdy;
      stdy_s2_q     <= stdy_s1_q;
      stab_cnt_q    <= stab_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      clr_cnt_q     <= clr_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_q     <= timeout_d;
      unlock_q      <= unlock_d;
      stdy_rst_q    <= (state_d == CLEAR_STDY);
      sys_rst_req_q <= (state_d != RUN);
      sys_ready_q   <= (state_d == RUN);
    end
  end

  assign stdy_rst     = stdy_rst_q;
  assign sys_rst_req  = sys_rst_req_q;
  assign sys_ready    = sys_ready_q;
  assign lock_timeout = timeout_q;
  assign unlock_count = unlock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with L=4, H=2, TIMEOUT=20, CNT_W=2.
module tb_pll_lock_supervisor;

  logic       clk_10m = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_locked_stdy = 1'b0;
  logic       stdy_rst, sys_rst_req, sys_ready, lock_timeout;
  logic [1:0] unlock_count;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES (4),
    .RESET_HOLD_CYCLES  (2),
    .LOCK_TIMEOUT_CYCLES(20),
    .CNT_W              (2)
  ) dut (
    .clk_10m        (clk_10m),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_locked_stdy(pll_locked_stdy),
    .stdy_rst       (stdy_rst),
    .sys_rst_req    (sys_rst_req),
    .sys_ready      (sys_ready),
    .lock_timeout   (lock_timeout),
    .unlock_count   (unlock_count)
  );

  always #5 clk_10m = ~clk_10m;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_10m);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_unlock;

    // Reset for three edges
    step(3);
    chk("rst_sys_rst_req", 32'(sys_rst_req), 1);
    chk("rst_sys_ready", 32'(sys_ready), 0);
    chk("rst_stdy_rst", 32'(stdy_rst), 0);
    chk("rst_unlock", 32'(unlock_count), 0);
    chk("rst_timeout", 32'(lock_timeout), 0);
    $display("reset done");

    // Acquisition: lock before relative edge 1 -> clear at 7..8, RUN at 11
    rst = 1'b0; pll_locked = 1'b1; pll_locked_stdy = 1'b1;
    step(6);  chk("acq_e6_stdy_rst", 32'(stdy_rst), 0);
              chk("acq_e6_rst_req", 32'(sys_rst_req), 1);
    step(1);  chk("acq_e7_stdy_rst", 32'(stdy_rst), 1);
    step(1);  chk("acq_e8_stdy_rst", 32'(stdy_rst), 1);
    step(1);  chk("acq_e9_stdy_rst", 32'(stdy_rst), 0);
              chk("acq_e9_rst_req", 32'(sys_rst_req), 1);
    step(1);  chk("acq_e10_ready", 32'(sys_ready), 0);
    step(1);  chk("acq_e11_ready", 32'(sys_ready), 1);
              chk("acq_e11_rst_req", 32'(sys_rst_req), 0);
              chk("acq_e11_timeout", 32'(lock_timeout), 0);
    $display("acquire: sys_ready=%0b", sys_ready);

    // Lock loss before edge 15 -> visible after edge 17
    step(3);  chk("run_e14_ready", 32'(sys_ready), 1);
    pll_locked = 1'b0;
    step(1);  chk("loss_e15_ready", 32'(sys_ready), 1);
    step(1);  chk("loss_e16_ready", 32'(sys_ready), 1);
    step(1);  chk("loss_e17_rst_req", 32'(sys_rst_req), 1);
              chk("loss_e17_unlock", 32'(unlock_count), 1);
    pll_locked = 1'b1;
    step(10); chk("relock_e27_ready", 32'(sys_ready), 0);
    step(1);  chk("relock_e28_ready", 32'(sys_ready), 1);
              chk("relock_e28_timeout", 32'(lock_timeout), 0);
    $display("relock: unlock_count=%0d", unlock_count);

    // Leave RUN at edge 31, then 2-high/1-low flapping; timeout must set at edge 51
    pll_locked = 1'b0;
    step(2);
    for (int e = 31; e <= 60; e++) begin
      pll_locked = ((e % 3) != 0);
      step(1);
      chk("flap_stdy_rst", 32'(stdy_rst), 0);
      chk("flap_ready", 32'(sys_ready), 0);
      chk("flap_unlock", 32'(unlock_count), 2);
      chk("flap_timeout", 32'(lock_timeout), (e >= 51) ? 1 : 0);
    end
    $display("flapping: lock_timeout=%0b", lock_timeout);

    // Sticky-lock input held low through HOLD
    pll_locked = 1'b0; pll_locked_stdy = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(7);  chk("hold_e70_stdy_rst", 32'(stdy_rst), 1);
    step(1);  chk("hold_e71_stdy_rst", 32'(stdy_rst), 1);
    step(1);  chk("hold_e72_stdy_rst", 32'(stdy_rst), 0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("hold_wait_rst_req", 32'(sys_rst_req), 1);
      chk("hold_wait_ready", 32'(sys_ready), 0);
    end
    pll_locked_stdy = 1'b1;
    step(1);  chk("stdy_e79_ready", 32'(sys_ready), 0);
    step(1);  chk("stdy_e80_ready", 32'(sys_ready), 0);
    step(1);  chk("stdy_e81_ready", 32'(sys_ready), 1);
              chk("stdy_e81_timeout", 32'(lock_timeout), 1);
              chk("stdy_e81_unlock", 32'(unlock_count), 2);
    $display("stdy release: sys_ready=%0b", sys_ready);

    // Three more losses: both inputs, stdy only, lock only -> saturate at 3
    exp_unlock = 2;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin pll_locked = 1'b0; pll_locked_stdy = 1'b0; end
      else if (n == 1) pll_locked_stdy = 1'b0;
      else pll_locked = 1'b0;
      exp_unlock = (exp_unlock < 3) ? exp_unlock + 1 : 3;
      step(2);  chk("sat_pre_ready", 32'(sys_ready), 1);
      step(1);  chk("sat_rst_req", 32'(sys_rst_req), 1);
                chk("sat_unlock", 32'(unlock_count), 32'(exp_unlock));
      pll_locked = 1'b0; pll_locked_stdy = 1'b1;
      step(3);
      pll_locked = 1'b1;
      step(10); chk("sat_relock_pre", 32'(sys_ready), 0);
      step(1);  chk("sat_relock_run", 32'(sys_ready), 1);
      $display("loss %0d: unlock_count=%0d", n + 3, unlock_count);
    end

    // Reset asserted during CLEAR_STDY
    pll_locked = 1'b0;
    step(5);  chk("pre_clr_unlock", 32'(unlock_count), 3);
    pll_locked = 1'b1;
    step(7);  chk("clr_stdy_rst", 32'(stdy_rst), 1);
    rst = 1'b1;
    step(1);  chk("abort_stdy_rst", 32'(stdy_rst), 0);
              chk("abort_rst_req", 32'(sys_rst_req), 1);
              chk("abort_ready", 32'(sys_ready), 0);
              chk("abort_unlock", 32'(unlock_count), 0);
              chk("abort_timeout", 32'(lock_timeout), 0);
    rst = 1'b0;
    step(6);  chk("restart_e6_stdy_rst", 32'(stdy_rst), 0);
    step(1);  chk("restart_e7_stdy_rst", 32'(stdy_rst), 1);
    $display("abort and restart done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
